// File: rtl/seq_mag_cmp.sv
// Multi-cycle magnitude comparator: walks WIDTH-bit operands one SLICE-bit slice per clock, MSB first.
// Define SEQ_MAG_CMP_FIXED_LAT_EN for constant-time operation (always N slices, no early exit).
module seq_mag_cmp #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             ready,
   output logic             valid,
   output logic             greater,
   output logic             less,
   output logic             equal
);

   localparam int N  = WIDTH / SLICE;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0]    LAST    = IW'(N - 1);
   localparam logic [SLICE-1:0] TOP_BIT = SLICE'(1) << (SLICE - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_param
      $error("seq_mag_cmp: SLICE must divide WIDTH");
   end

   logic [0:0]       state;
   logic [WIDTH-1:0] a_p0;
   logic [WIDTH-1:0] b_p0;
   logic             sm_p0;
   logic [IW-1:0]    idx_p0;

   logic [SLICE-1:0] sa;
   logic [SLICE-1:0] sb;
   logic             slice_gt;
   logic             slice_lt;

   // Slice idx counted from the MSB; the sign bit is flipped so two's-complement orders as unsigned.
   function automatic logic [SLICE-1:0] pick_slice(input logic [WIDTH-1:0] v,
                                                   input logic [IW-1:0]    i,
                                                   input logic             inv);
      logic [WIDTH-1:0] sh;
      logic [SLICE-1:0] s;
      sh = v << (int'(i) * SLICE);
      s  = sh[WIDTH-1 -: SLICE];
      if (inv) s = s ^ TOP_BIT;
      return s;
   endfunction

   always_comb begin
      sa       = pick_slice(a_p0, idx_p0, sm_p0 && (idx_p0 == '0));
      sb       = pick_slice(b_p0, idx_p0, sm_p0 && (idx_p0 == '0));
      slice_gt = (sa > sb);
      slice_lt = (sa < sb);
   end

   assign ready = (state == IDLE);

`ifdef SEQ_MAG_CMP_FIXED_LAT_EN
   logic dec_p0;
   logic dgt_p0;
   logic dlt_p0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         a_p0    <= '0;
         b_p0    <= '0;
         sm_p0   <= 1'b0;
         idx_p0  <= '0;
         dec_p0  <= 1'b0;
         dgt_p0  <= 1'b0;
         dlt_p0  <= 1'b0;
         valid   <= 1'b0;
         greater <= 1'b0;
         less    <= 1'b0;
         equal   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               valid <= 1'b0;
               if (start) begin
                  a_p0    <= a;
                  b_p0    <= b;
                  sm_p0   <= signed_mode;
                  idx_p0  <= '0;
                  dec_p0  <= 1'b0;
                  dgt_p0  <= 1'b0;
                  dlt_p0  <= 1'b0;
                  greater <= 1'b0;
                  less    <= 1'b0;
                  equal   <= 1'b0;
                  state   <= RUN;
               end
            end
            RUN: begin
               // The first differing slice wins, but the walk always runs to the last slice.
               if (idx_p0 == LAST) begin
                  valid <= 1'b1;
                  state <= IDLE;
                  if (dec_p0) begin
                     greater <= dgt_p0;
                     less    <= dlt_p0;
                  end else if (slice_gt) begin
                     greater <= 1'b1;
                  end else if (slice_lt) begin
                     less    <= 1'b1;
                  end else begin
                     equal   <= 1'b1;
                  end
               end else begin
                  if (!dec_p0 && (slice_gt || slice_lt)) begin
                     dec_p0 <= 1'b1;
                     dgt_p0 <= slice_gt;
                     dlt_p0 <= slice_lt;
                  end
                  idx_p0 <= idx_p0 + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         a_p0    <= '0;
         b_p0    <= '0;
         sm_p0   <= 1'b0;
         idx_p0  <= '0;
         valid   <= 1'b0;
         greater <= 1'b0;
         less    <= 1'b0;
         equal   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               valid <= 1'b0;
               if (start) begin
                  a_p0    <= a;
                  b_p0    <= b;
                  sm_p0   <= signed_mode;
                  idx_p0  <= '0;
                  greater <= 1'b0;
                  less    <= 1'b0;
                  equal   <= 1'b0;
                  state   <= RUN;
               end
            end
            RUN: begin
               // Stop on the first differing slice; equal only once every slice matched.
               if (slice_gt) begin
                  greater <= 1'b1;
                  valid   <= 1'b1;
                  state   <= IDLE;
               end else if (slice_lt) begin
                  less    <= 1'b1;
                  valid   <= 1'b1;
                  state   <= IDLE;
               end else if (idx_p0 == LAST) begin
                  equal   <= 1'b1;
                  valid   <= 1'b1;
                  state   <= IDLE;
               end else begin
                  idx_p0  <= idx_p0 + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`endif

endmodule

// File: doc/seq_mag_cmp.md
Name: seq_mag_cmp

Overview:
Parametrised multi-cycle magnitude comparator, the successor to the fixed 2-bit/4-bit combinational comparators.
- Compares two WIDTH-bit operands one SLICE-bit slice per clock, MSB slice first.
- Supports unsigned or two's-complement mode, selected per operation.
- Start/valid handshake; terminates early on the first differing slice.
- Used where wide compares must not sit in a single combinational path.

Parameters:
WIDTH, 16, operand width in bits.
SLICE, 4, bits compared per cycle; must divide WIDTH; N = WIDTH/SLICE slices (N=1 legal).

Ports:
clk  input  1  clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; accepted only when ready=1.
a  input  WIDTH  operand A, sampled on accept.
b  input  WIDTH  operand B, sampled on accept.
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled on accept.
ready  output  1  high in IDLE; combinational from state.
valid  output  1  one-cycle pulse, result available.
greater  output  1  A > B.
less  output  1  A < B.
equal  output  1  A == B.

Behaviour:
- Reset state:
  - state IDLE; ready=1.
  - valid, greater, less, equal = 0.
  - Internal operand registers and slice index = 0.
- States:
  - IDLE: ready=1. On start=1 at edge k: latch a, b, signed_mode; idx=0; clear greater/less/equal to 0; go to RUN.
  - RUN: ready=0. Each edge compares slice idx, bits [WIDTH-1-idx*SLICE -: SLICE].
    - Slices differ: set greater/less, assert valid, go to IDLE.
    - Slices equal and idx=N-1: set equal=1, assert valid, go to IDLE.
    - Otherwise: idx++.
- Signed mode:
  - Slice 0 is compared with its top bit (operand bit WIDTH-1) inverted on both operands.
  - All other slices compare unsigned.
- Latency:
  - First differing slice is i (0 = MSB): valid asserts after edge k+1+i.
  - Equal operands: valid asserts after edge k+N.
  - Best case is 1 cycle after accept; worst case is N.
- Outputs:
  - Exactly one of greater/less/equal is 1 while valid=1.
  - Result flags hold their value after valid drops, until the next accepted start clears them.
- Boundary conditions:
  - start while ready=0 is ignored: no latch, no queueing, operation in flight unaffected.
  - Back-to-back: start sampled in the cycle valid=1 is accepted (state already IDLE). valid drops at that edge and the flags clear.
  - a/b/signed_mode changing during RUN has no effect.
  - reset during RUN returns to IDLE on the same edge: all outputs 0, no valid pulse. reset has priority over start.
  - N=1: every operation completes with valid 1 cycle after accept.

Optional Feature:
SEQ_MAG_CMP_FIXED_LAT_EN
- Defined:
  - Early exit disabled; always processes all N slices.
  - Result is decided by the first differing slice, MSB-first.
  - valid always asserts exactly N cycles after accept, regardless of data (constant-time).
- Undefined: early-exit behaviour as described in Behaviour.

Test Plan (WIDTH=16, SLICE=4):
1. Unsigned, a=0x8000, b=0x7FFF -> greater=1, valid one cycle after accept, less=equal=0.
2. Signed, a=0x8000, b=0x7FFF -> less=1, valid one cycle after accept. Signed, a=0xFFFF, b=0x0001 -> less=1 in one cycle.
3. a=b=0x1234, either mode -> equal=1, valid 4 cycles after accept. a=0x1235, b=0x1234 -> greater=1 at 4 cycles. a=0x1204, b=0x1234 -> less=1 at 3 cycles.
4. Issue a second start with different data one cycle after accepting a=0x0001, b=0x0002 -> second start ignored, ready=0; result less=1 at 4 cycles. Then start in the valid cycle with a=0xF000, b=0x0000 unsigned -> accepted, greater=1 one cycle later.
5. Assert reset 2 cycles into an equal-operand compare -> next cycle ready=1, valid=0, all flags 0, no valid pulse afterwards. Then a=0x0010, b=0x0010 -> equal=1 at 4 cycles.
6. With SEQ_MAG_CMP_FIXED_LAT_EN, repeat scenarios 1-2 -> same flags, valid exactly 4 cycles after accept. Exhaustive sweep at WIDTH=4, SLICE=2 over all 256 {a,b} pairs in both modes, checked against $signed/unsigned reference compare.
